// File: rtl/axi_ndp_gate.sv
// axi_ndp_gate: quiesces host AXI write (and optionally read) traffic so an
// NDP engine can take exclusive ownership of memory.
// The host side drains its outstanding writes before ndp_grant is raised.
// Optional feature macro: AXI_NDP_GATE_READ_EN. When it is defined, the AR
// channel is gated and outstanding reads are also drained before the grant.
// Handshake semantics: a transfer happens on a channel in any cycle where
// valid and ready are both high at posedge clk. While blocked, the gate hides
// valid from the slave and ready from the master, so a held request simply
// stays pending and is transferred exactly once after the block lifts.
module axi_ndp_gate #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              stall_req,
    input  logic              s_awvalid,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              m_awready,
    output logic              m_awvalid,
    output logic              s_awready,
    output logic [ADDR_W-1:0] m_awaddr,
    input  logic              s_wvalid,
    input  logic              m_wready,
    input  logic              s_wlast,
    input  logic              m_bvalid,
    input  logic              s_bready,
    input  logic              s_arvalid,
    input  logic              m_arready,
    output logic              m_arvalid,
    output logic              s_arready,
    input  logic              m_rvalid,
    input  logic              s_rready,
    input  logic              m_rlast,
    output logic              ndp_grant,
    output logic [CNT_W-1:0]  wr_outstanding,
    output logic [CNT_W-1:0]  rd_outstanding,
    output logic [1:0]        state
);

    localparam logic [1:0] ST_OPEN   = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_CLOSED = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] wr_q;
    logic             wbusy_q;
    logic             aw_block;
    logic             quiet;
    logic             rd_idle;
    logic             aw_hs;
    logic             b_hs;
    logic             w_hs;

    // Saturating up/down counter step; simultaneous inc and dec cancel.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                  input logic inc,
                                                  input logic dec);
        logic [CNT_W-1:0] n;
        n = c;
        if (inc && !dec && c != CNT_MAX) begin
            n = c + CNT_ONE;
        end else if (dec && !inc && c != CNT_ZERO) begin
            n = c - CNT_ONE;
        end
        return n;
    endfunction

    assign aw_hs = m_awvalid & m_awready;
    assign b_hs  = m_bvalid & s_bready;
    assign w_hs  = s_wvalid & m_wready;

    assign state          = state_q;
    assign wr_outstanding = wr_q;

    // State register.
    always_ff @(posedge clk) begin
        if (aresetn) begin
            state_q <= ST_OPEN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the unused encoding recovers to OPEN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OPEN:   if (stall_req) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!stall_req) begin
                    state_d = ST_OPEN;
                end else if (quiet) begin
                    state_d = ST_CLOSED;
                end
            end
            ST_CLOSED: if (!stall_req) state_d = ST_OPEN;
            default:   state_d = ST_OPEN;
        endcase
    end

    // Outputs decoded from registered state and counters.
    always_comb begin
        ndp_grant = (state_q == ST_CLOSED);
        aw_block  = (state_q != ST_OPEN) | (wr_q == CNT_MAX);
        m_awvalid = s_awvalid & ~aw_block;
        s_awready = m_awready & ~aw_block;
        m_awaddr  = aw_block ? '0 : s_awaddr;
        quiet     = (wr_q == CNT_ZERO) & ~wbusy_q & rd_idle;
    end

    // Outstanding write-address count and mid-burst write-data tracking.
    always_ff @(posedge clk) begin
        if (aresetn) begin
            wr_q    <= '0;
            wbusy_q <= 1'b0;
        end else begin
            wr_q <= cnt_next(wr_q, aw_hs, b_hs);
            if (w_hs) begin
                wbusy_q <= ~s_wlast;
            end
        end
    end

`ifdef AXI_NDP_GATE_READ_EN
    logic [CNT_W-1:0] rd_q;
    logic             ar_block;
    logic             ar_hs;
    logic             r_done;

    assign ar_block       = (state_q != ST_OPEN) | (rd_q == CNT_MAX);
    assign m_arvalid      = s_arvalid & ~ar_block;
    assign s_arready      = m_arready & ~ar_block;
    assign ar_hs          = m_arvalid & m_arready;
    assign r_done         = m_rvalid & s_rready & m_rlast;
    assign rd_idle        = (rd_q == CNT_ZERO);
    assign rd_outstanding = rd_q;

    // Outstanding read count; a burst retires on its last R beat.
    always_ff @(posedge clk) begin
        if (aresetn) begin
            rd_q <= '0;
        end else begin
            rd_q <= cnt_next(rd_q, ar_hs, r_done);
        end
    end
`else
    logic unused_r_inputs;

    assign m_arvalid       = s_arvalid;
    assign s_arready       = m_arready;
    assign rd_outstanding  = '0;
    assign rd_idle         = 1'b1;
    assign unused_r_inputs = m_rvalid ^ s_rready ^ m_rlast;
`endif

endmodule

// File: tb/tb_axi_ndp_gate.sv
// Bench for axi_ndp_gate: directed scenarios followed by random traffic.
// Two instances share stimulus: a default-width one and a CNT_W=2 one so the
// counter ceiling is reachable. A transaction-level reference model predicts
// every output each cycle.
module tb_axi_ndp_gate;

`ifdef AXI_NDP_GATE_READ_EN
    localparam bit RD_EN = 1'b1;
`else
    localparam bit RD_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        st;
    logic        awv, awrdy, wv, wrdy, wl, bv, brdy;
    logic        arv, arrdy, rv, rrdy, rl;
    logic [31:0] awaddr;

    logic        d0_mawv, d0_saw, d0_marv, d0_sar, d0_grant;
    logic [31:0] d0_maddr;
    logic [5:0]  d0_wr, d0_rd;
    logic [1:0]  d0_state;
    logic        d1_mawv, d1_saw, d1_marv, d1_sar, d1_grant;
    logic [31:0] d1_maddr;
    logic [1:0]  d1_wr, d1_rd;
    logic [1:0]  d1_state;

    int total = 0;
    int bad   = 0;

    // Reference model state: phase 0=open 1=drain 2=closed.
    int mph[2];
    int mwr[2];
    int mrd[2];
    bit mwb[2];
    int mmax[2];

    axi_ndp_gate #(.ADDR_W(32), .CNT_W(6)) dut (
        .clk(clk), .aresetn(rst), .stall_req(st),
        .s_awvalid(awv), .s_awaddr(awaddr), .m_awready(awrdy),
        .m_awvalid(d0_mawv), .s_awready(d0_saw), .m_awaddr(d0_maddr),
        .s_wvalid(wv), .m_wready(wrdy), .s_wlast(wl),
        .m_bvalid(bv), .s_bready(brdy),
        .s_arvalid(arv), .m_arready(arrdy), .m_arvalid(d0_marv), .s_arready(d0_sar),
        .m_rvalid(rv), .s_rready(rrdy), .m_rlast(rl),
        .ndp_grant(d0_grant), .wr_outstanding(d0_wr), .rd_outstanding(d0_rd),
        .state(d0_state)
    );

    axi_ndp_gate #(.ADDR_W(32), .CNT_W(2)) dut_small (
        .clk(clk), .aresetn(rst), .stall_req(st),
        .s_awvalid(awv), .s_awaddr(awaddr), .m_awready(awrdy),
        .m_awvalid(d1_mawv), .s_awready(d1_saw), .m_awaddr(d1_maddr),
        .s_wvalid(wv), .m_wready(wrdy), .s_wlast(wl),
        .m_bvalid(bv), .s_bready(brdy),
        .s_arvalid(arv), .m_arready(arrdy), .m_arvalid(d1_marv), .s_arready(d1_sar),
        .m_rvalid(rv), .s_rready(rrdy), .m_rlast(rl),
        .ndp_grant(d1_grant), .wr_outstanding(d1_wr), .rd_outstanding(d1_rd),
        .state(d1_state)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mph[k] = 0;
            mwr[k] = 0;
            mrd[k] = 0;
            mwb[k] = 1'b0;
        end
    endtask

    // Compare one instance's outputs with what the model predicts right now.
    task automatic check_inst(input int k, input logic mawv, input logic saw,
                              input logic [31:0] maddr, input logic marv, input logic sar,
                              input logic grant, input logic [31:0] wr,
                              input logic [31:0] rd, input logic [31:0] ph);
        bit aw_open;
        bit ar_open;
        aw_open = (mph[k] == 0) && (mwr[k] < mmax[k]);
        ar_open = (mph[k] == 0) && (mrd[k] < mmax[k]);
        check_val($sformatf("d%0d_m_awvalid", k), mawv, awv && aw_open);
        check_val($sformatf("d%0d_s_awready", k), saw, awrdy && aw_open);
        check_val($sformatf("d%0d_m_awaddr", k), maddr, aw_open ? awaddr : 32'h0);
        check_val($sformatf("d%0d_m_arvalid", k), marv, RD_EN ? (arv && ar_open) : arv);
        check_val($sformatf("d%0d_s_arready", k), sar, RD_EN ? (arrdy && ar_open) : arrdy);
        check_val($sformatf("d%0d_grant", k), grant, mph[k] == 2);
        check_val($sformatf("d%0d_wr_out", k), wr, mwr[k]);
        check_val($sformatf("d%0d_rd_out", k), rd, mrd[k]);
        check_val($sformatf("d%0d_state", k), ph, mph[k]);
    endtask

    // Advance the model by one clock using the inputs just sampled.
    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            bit aw_open;
            bit ar_open;
            bit calm;
            int aw_n;
            int b_n;
            int ar_n;
            int r_n;
            aw_open = (mph[k] == 0) && (mwr[k] < mmax[k]);
            ar_open = (mph[k] == 0) && (mrd[k] < mmax[k]);
            aw_n = (awv && awrdy && aw_open) ? 1 : 0;
            b_n  = (bv && brdy) ? 1 : 0;
            ar_n = (RD_EN && arv && arrdy && ar_open) ? 1 : 0;
            r_n  = (RD_EN && rv && rrdy && rl) ? 1 : 0;
            calm = (mwr[k] == 0) && !mwb[k] && (mrd[k] == 0);
            if (rst) begin
                mph[k] = 0;
                mwr[k] = 0;
                mrd[k] = 0;
                mwb[k] = 1'b0;
            end else begin
                if (mph[k] == 0) mph[k] = st ? 1 : 0;
                else if (mph[k] == 1) mph[k] = !st ? 0 : (calm ? 2 : 1);
                else mph[k] = st ? 2 : 0;
                mwr[k] = mwr[k] + aw_n - b_n;
                if (mwr[k] < 0) mwr[k] = 0;
                mrd[k] = mrd[k] + ar_n - r_n;
                if (mrd[k] < 0) mrd[k] = 0;
                if (wv && wrdy) mwb[k] = !wl;
            end
        end
    endtask

    // One cycle: check at the falling edge, then clock model and DUT together.
    task automatic step();
        @(negedge clk);
        check_inst(0, d0_mawv, d0_saw, d0_maddr, d0_marv, d0_sar, d0_grant,
                   32'(d0_wr), 32'(d0_rd), 32'(d0_state));
        check_inst(1, d1_mawv, d1_saw, d1_maddr, d1_marv, d1_sar, d1_grant,
                   32'(d1_wr), 32'(d1_rd), 32'(d1_state));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        st = 0; awv = 0; awrdy = 0; awaddr = 32'h0; wv = 0; wrdy = 0; wl = 0;
        bv = 0; brdy = 0; arv = 0; arrdy = 0; rv = 0; rrdy = 0; rl = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        mmax[0] = 63;
        mmax[1] = 3;
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_val("reset_state", d0_state, 0);
        check_val("reset_grant", d0_grant, 0);
        check_val("reset_wr", d0_wr, 0);
        rst = 1'b0;

        // Three writes outstanding, then drain until the last B retires.
        awv = 1; awrdy = 1; awaddr = 32'h40;
        repeat (3) step();
        check_val("drain3_wr", d0_wr, 3);
        awv = 0; st = 1;
        step();
        check_val("drain3_enter", d0_state, 1);
        awv = 1; bv = 1; brdy = 1;
        repeat (3) step();
        check_val("drain3_awblocked", d0_mawv, 0);
        check_val("drain3_wr0", d0_wr, 0);
        check_val("drain3_nogrant", d0_grant, 0);
        bv = 0; brdy = 0;
        step();
        check_val("drain3_grant", d0_grant, 1);
        check_val("drain3_closed_awblocked", d0_mawv, 0);

        // Stall while a 4-beat W burst is in flight with no AW outstanding.
        idle(); do_reset();
        wv = 1; wrdy = 1; wl = 0;
        step();
        st = 1;
        repeat (2) step();
        wl = 1;
        step();
        check_val("wburst_still_drain", d0_state, 1);
        wv = 0; wl = 0;
        step();
        check_val("wburst_closed", d0_state, 2);

        // Simultaneous AW and B, and the counter ceiling on the small instance.
        idle(); do_reset();
        awv = 1; awrdy = 1;
        repeat (2) step();
        bv = 1; brdy = 1;
        step();
        check_val("same_cycle_hold", d0_wr, 2);
        bv = 0; brdy = 0;
        step();
        step();
        check_val("small_sat_wr", d1_wr, 3);
        check_val("small_sat_awready", d1_saw, 0);
        check_val("big_not_sat_wr", d0_wr, 4);

        // Stall dropped mid-drain with an AW held: it passes exactly once.
        idle(); do_reset();
        awv = 1; awrdy = 1;
        step();
        awv = 0; st = 1;
        step();
        awv = 1; awaddr = 32'h1000;
        step();
        check_val("held_aw_blocked", d0_mawv, 0);
        check_val("held_aw_addr0", d0_maddr, 0);
        check_val("held_aw_wr", d0_wr, 1);
        st = 0;
        step();
        check_val("held_aw_open", d0_state, 0);
        check_val("held_aw_addr", d0_maddr, 32'h1000);
        step();
        awv = 0;
        step();
        check_val("held_aw_once", d0_wr, 2);

        // Reset while draining with five outstanding, then while closed.
        idle(); do_reset();
        awv = 1; awrdy = 1;
        repeat (5) step();
        awv = 0; st = 1;
        repeat (2) step();
        check_val("rst_drain_pre", d0_wr, 5);
        rst = 1; step(); rst = 0;
        check_val("rst_drain_state", d0_state, 0);
        check_val("rst_drain_wr", d0_wr, 0);
        check_val("rst_drain_grant", d0_grant, 0);
        repeat (2) step();
        check_val("rst_closed_pre", d0_grant, 1);
        rst = 1; step(); rst = 0;
        check_val("rst_closed_state", d0_state, 0);
        check_val("rst_closed_grant", d0_grant, 0);

        // Read traffic and the grant.
        idle(); do_reset();
`ifdef AXI_NDP_GATE_READ_EN
        arv = 1; arrdy = 1;
        repeat (2) step();
        check_val("rd_two", d0_rd, 2);
        arv = 0; st = 1;
        step();
        rv = 1; rrdy = 1; rl = 0;
        step();
        rl = 1;
        step();
        check_val("rd_one_left_nogrant", d0_grant, 0);
        step();
        check_val("rd_zero_nogrant", d0_grant, 0);
        rv = 0; rl = 0;
        step();
        check_val("rd_grant", d0_grant, 1);
`else
        arv = 1; arrdy = 1; st = 1;
        step();
        check_val("rd_passthru", d0_marv, 1);
        rv = 1; rrdy = 1; rl = 0;
        step();
        check_val("rd_ignored_grant", d0_grant, 1);
        check_val("rd_tied", d0_rd, 0);
`endif

        // Random traffic against the model.
        idle();
        for (int i = 0; i < 3000; i++) begin
            awv    = ($urandom_range(0, 3) == 0);
            awaddr = $urandom;
            awrdy  = ($urandom_range(0, 1) == 0);
            wv     = ($urandom_range(0, 1) == 0);
            wrdy   = ($urandom_range(0, 1) == 0);
            wl     = ($urandom_range(0, 2) == 0);
            bv     = st ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 4) == 0);
            brdy   = ($urandom_range(0, 3) != 0);
            arv    = ($urandom_range(0, 3) == 0);
            arrdy  = ($urandom_range(0, 1) == 0);
            rv     = ($urandom_range(0, 1) == 0);
            rrdy   = ($urandom_range(0, 3) != 0);
            rl     = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 19) == 0) st = ~st;
            rst    = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
